// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
//
// Ports
//   clk        system clock, all state on the rising edge
//   reset      synchronous, active-high
//   mem_addr   CPU data byte address
//   mem_we     CPU store strobe, sampled at the rising edge
//   mem_re     CPU load strobe, read path is combinational
//   mem_wdata  store data
//   mem_rdata  load data, zero unless this block is selected and read
//   mem_sel    high when mem_addr falls inside the 16-byte register block
//   tx         serial line, idle high, registered
//
// Registers (offset = mem_addr[3:0])
//   0x0 TXDATA  store pushes wdata[7:0], load returns 0
//   0x4 STATUS  {count[6:4], overflow, busy, empty, full}
//   0x8 CLEAR   any store clears overflow
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | line high, pops FIFO head when data is queued
// S_START | start bit (low) for CLKS_PER_BIT cycles
// S_DATA  | 8 data bits, LSB first, CLKS_PER_BIT each
// S_STOP  | stop bit (high) for CLKS_PER_BIT cycles
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_sel,
  output logic        tx
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;

  logic [3:0]      offset;
  logic            wr_txdata, wr_clear;
  logic            fifo_full, fifo_empty;
  logic            pop, push, drop;
  logic [2:0]      count3;
  logic [31:0]     status;

  assign mem_sel    = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign offset     = mem_addr[3:0];
  assign wr_txdata  = mem_sel & mem_we & (offset == 4'h0);
  assign wr_clear   = mem_sel & mem_we & (offset == 4'h8);
  assign fifo_full  = (count_q == C_FULL);
  assign fifo_empty = (count_q == '0);
  assign pop        = (state_q == S_IDLE) & ~fifo_empty;
  // A pop on the same edge frees a slot, so a store to a full FIFO still lands.
  assign push       = wr_txdata & (~fifo_full | pop);
  assign drop       = wr_txdata & fifo_full & ~pop;
  assign count3     = 3'(count_q);
  assign status     = {25'd0, count3, ovf_q, (state_q != S_IDLE), fifo_empty, fifo_full};
  assign tx         = tx_q;

  always_comb begin
    mem_rdata = 32'd0;
    if (mem_sel && mem_re && (offset == 4'h4)) mem_rdata = status;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (wr_clear)  ovf_d = 1'b0;
    else if (drop) ovf_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d   = fifo_q[rd_ptr_q];
          bit_cnt_d = '0;
          timer_d   = '0;
          state_d   = S_START;
          tx_d      = 1'b0;
        end
      end
      S_START: begin
        if (timer_q == T_LAST) begin
          timer_d = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        if (timer_q == T_LAST) begin
          timer_d = '0;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            // tx is registered, so present the bit that is about to become shift[0].
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[1];
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STOP: begin
        if (timer_q == T_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage needs no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem_wdata[7:0];
  end

endmodule
